// File: rtl/gvt_round_sched_pkg.sv
// ----------------------------------------------------------------------------
// gvt_round_sched_pkg
// Shared types and constants for the GVT round scheduler.
//   VT_WIDTH     : width of a virtual time {ts, tb}
//   vt_t         : packed virtual time, compared unsigned as a whole
//   VT_IDLE      : all-ones virtual time reported by an idle tile
//   gvt_state_t  : round sequencing states
// ----------------------------------------------------------------------------
package gvt_round_sched_pkg;

    localparam int unsigned TS_WIDTH_DEF = 32;
    localparam int unsigned TB_WIDTH_DEF = 32;
    localparam int unsigned VT_WIDTH     = TS_WIDTH_DEF + TB_WIDTH_DEF;

    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0] ts;
        logic [TB_WIDTH_DEF-1:0] tb;
    } vt_t;

    localparam vt_t VT_IDLE = vt_t'({VT_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        REDUCE  = 2'd2,
        PUBLISH = 2'd3
    } gvt_state_t;

endpackage : gvt_round_sched_pkg

// File: rtl/gvt_round_sched_min_reduce.sv
// ----------------------------------------------------------------------------
// gvt_min_reduce
// Combinational minimum over N_TILES packed virtual times, built as a
// balanced binary tree of 2-input unsigned comparators. Leaves beyond
// N_TILES are padded with all ones so they never win.
// Ports:
//   vt_i     in  N_TILES*VTW  packed VTs, tile i at [i*VTW +: VTW]
//   min_c_o  out VTW          combinational minimum
// ----------------------------------------------------------------------------
module gvt_min_reduce
    import gvt_round_sched_pkg::*;
#(
    parameter int unsigned N_TILES = 1,
    parameter int unsigned VTW     = VT_WIDTH
) (
    input  logic [N_TILES*VTW-1:0] vt_i,
    output logic [VTW-1:0]         min_c_o
);

    localparam int unsigned N_PAD   = 1 << $clog2(N_TILES);
    localparam int unsigned N_NODES = 2 * N_PAD - 1;

    generate
        if (N_TILES == 1) begin : g_single
            // A single tile needs no comparison.
            assign min_c_o = vt_i;
        end else begin : g_tree
            // Heap-ordered tree: node k has children 2k+1 and 2k+2,
            // leaves occupy N_PAD-1 .. N_NODES-1.
            logic [VTW-1:0] node [N_NODES];

            always_comb begin
                for (int i = 0; i < int'(N_TILES); i++) begin
                    node[int'(N_PAD) - 1 + i] = vt_i[i*VTW +: VTW];
                end
                for (int i = int'(N_TILES); i < int'(N_PAD); i++) begin
                    node[int'(N_PAD) - 1 + i] = {VTW{1'b1}};
                end
                for (int k = int'(N_PAD) - 2; k >= 0; k--) begin
                    node[k] = (node[2*k+2] < node[2*k+1]) ? node[2*k+2] : node[2*k+1];
                end
            end

            assign min_c_o = node[0];
        end
    endgenerate

endmodule : gvt_min_reduce

// File: rtl/gvt_round_sched.sv
// ----------------------------------------------------------------------------
// gvt_round_sched
// Periodic global virtual time scheduler. Every 2^LOG_GVT_PERIOD enabled
// cycles (or on force_round) it requests every tile's LVT, collects the
// replies, reduces them to a minimum and publishes a monotonic GVT.
//
// Optional build macro: GVT_TIMEOUT_EN
//   When defined, a watchdog aborts a round that stays in REQ for
//   2^LOG_GVT_TIMEOUT cycles (pulses gvt_timeout, no publish).
//   When undefined, REQ waits indefinitely and gvt_timeout is 0.
//
// Ports:
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   en              in   enables periodic rounds
//   force_round     in   one-cycle request for an immediate round
//   tile_lvt_req    out  per-tile LVT request (level)
//   tile_lvt_valid  in   per-tile reply valid
//   tile_lvt        in   packed {ts,tb} per tile
//   gvt             out  last published GVT
//   gvt_valid       out  one-cycle pulse on publish
//   gvt_regress     out  sticky: a round minimum was below gvt
//   gvt_timeout     out  one-cycle pulse on round abort
//   rounds          out  completed round count (wraps)
// ----------------------------------------------------------------------------
module gvt_round_sched
    import gvt_round_sched_pkg::*;
#(
    parameter int unsigned N_TILES         = 1,
    parameter int unsigned TS_WIDTH        = TS_WIDTH_DEF,
    parameter int unsigned TB_WIDTH        = TB_WIDTH_DEF,
    parameter int unsigned LOG_GVT_PERIOD  = 5,
    parameter int unsigned LOG_GVT_TIMEOUT = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   force_round,
    output logic [N_TILES-1:0]                     tile_lvt_req,
    input  logic [N_TILES-1:0]                     tile_lvt_valid,
    input  logic [N_TILES*(TS_WIDTH+TB_WIDTH)-1:0] tile_lvt,
    output logic [TS_WIDTH+TB_WIDTH-1:0]           gvt,
    output logic                                   gvt_valid,
    output logic                                   gvt_regress,
    output logic                                   gvt_timeout,
    output logic [31:0]                            rounds
);

    localparam int unsigned VTW   = TS_WIDTH + TB_WIDTH;
    localparam int unsigned PER_W = LOG_GVT_PERIOD;

    // Elaboration-time parameter sanity.
    generate
        if (LOG_GVT_PERIOD < 1 || LOG_GVT_TIMEOUT < 1) begin : g_bad_param
            $error("gvt_round_sched: LOG_GVT_PERIOD and LOG_GVT_TIMEOUT must be >= 1");
        end
    endgenerate

    gvt_state_t               state_q, state_d;
    logic [PER_W-1:0]         per_cnt_q, per_cnt_d;
    logic                     pending_q, pending_d;
    logic [N_TILES-1:0]       req_q, req_d;
    logic [N_TILES-1:0]       seen_q, seen_d;
    logic [N_TILES*VTW-1:0]   lat_q, lat_d;
    logic [VTW-1:0]           min_q, min_d;
    logic [VTW-1:0]           gvt_q, gvt_d;
    logic                     gvt_valid_q, gvt_valid_d;
    logic                     regress_q, regress_d;
    logic [31:0]              rounds_q, rounds_d;
    logic [N_TILES-1:0]       accept_c;
    logic                     wrap_c;
    logic [VTW-1:0]           min_c;
`ifdef GVT_TIMEOUT_EN
    logic [LOG_GVT_TIMEOUT-1:0] wd_q, wd_d;
    logic                       timeout_q, timeout_d;
`endif

    // Minimum over the latched replies; sampled into min_q in REDUCE.
    gvt_min_reduce #(
        .N_TILES (N_TILES),
        .VTW     (VTW)
    ) u_min_reduce (
        .vt_i    (lat_q),
        .min_c_o (min_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, round sequencing and datapath updates.
    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        pending_d   = pending_q;
        req_d       = req_q;
        seen_d      = seen_q;
        lat_d       = lat_q;
        min_d       = min_q;
        gvt_d       = gvt_q;
        gvt_valid_d = 1'b0;
        regress_d   = regress_q;
        rounds_d    = rounds_q;
        accept_c    = req_q & tile_lvt_valid;
        wrap_c      = en && (per_cnt_q == {PER_W{1'b1}});
`ifdef GVT_TIMEOUT_EN
        wd_d        = wd_q;
        timeout_d   = 1'b0;
`endif

        if (en) begin
            per_cnt_d = per_cnt_q + PER_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
                    req_d     = {N_TILES{1'b1}};
                    seen_d    = '0;
`ifdef GVT_TIMEOUT_EN
                    wd_d      = '0;
`endif
                end
            end

            REQ: begin
                // Replies are only accepted while that tile is still requested.
                req_d  = req_q & ~accept_c;
                seen_d = seen_q | accept_c;
                for (int i = 0; i < int'(N_TILES); i++) begin
                    if (accept_c[i]) begin
                        lat_d[i*VTW +: VTW] = tile_lvt[i*VTW +: VTW];
                    end
                end
                if (&seen_d) begin
                    state_d = REDUCE;
                end
`ifdef GVT_TIMEOUT_EN
                // A round completing on the last allowed cycle still publishes.
                else if (wd_q == {LOG_GVT_TIMEOUT{1'b1}}) begin
                    state_d   = IDLE;
                    req_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + LOG_GVT_TIMEOUT'(1);
                end
`endif
            end

            REDUCE: begin
                min_d   = min_c;
                state_d = PUBLISH;
            end

            PUBLISH: begin
                // GVT never moves backwards; a lower minimum is flagged instead.
                if (min_q >= gvt_q) begin
                    gvt_d = min_q;
                end else begin
                    regress_d = 1'b1;
                end
                gvt_valid_d = 1'b1;
                rounds_d    = rounds_q + 32'd1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Late-arriving requests fold into a single pending round.
        if (wrap_c || force_round) begin
            pending_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q   <= '0;
            pending_q   <= 1'b0;
            req_q       <= '0;
            seen_q      <= '0;
            lat_q       <= '0;
            min_q       <= '0;
            gvt_q       <= '0;
            gvt_valid_q <= 1'b0;
            regress_q   <= 1'b0;
            rounds_q    <= '0;
        end else begin
            per_cnt_q   <= per_cnt_d;
            pending_q   <= pending_d;
            req_q       <= req_d;
            seen_q      <= seen_d;
            lat_q       <= lat_d;
            min_q       <= min_d;
            gvt_q       <= gvt_d;
            gvt_valid_q <= gvt_valid_d;
            regress_q   <= regress_d;
            rounds_q    <= rounds_d;
        end
    end

`ifdef GVT_TIMEOUT_EN
    // Reply watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign gvt_timeout = timeout_q;
`else
    assign gvt_timeout = 1'b0;
`endif

    assign tile_lvt_req = req_q;
    assign gvt          = gvt_q;
    assign gvt_valid    = gvt_valid_q;
    assign gvt_regress  = regress_q;
    assign rounds       = rounds_q;

endmodule : gvt_round_sched
